// File: rtl/step_accum_pair.sv
// step_accum_pair
//
// Two W-bit accumulators, a and b, that step together under a small FSM
// (IDLE -> RUN -> DONE). Each step adds STEP_LO to one accumulator and
// STEP_HI to the other; sel picks which gets which. A run is started with
// a bound n and takes exactly n steps, with pauses (hold) and early exit
// (abort) available while it runs.
//
// Ports
//   clk       in   1  clock, rising edge
//   rst       in   1  synchronous active-high reset
//   start     in   1  launch request, sampled in IDLE/DONE only
//   bound_in  in   W  iteration bound, captured into n on an accepted start
//   sel       in   1  1: a+=STEP_LO, b+=STEP_HI ; 0: a+=STEP_HI, b+=STEP_LO
//   hold      in   1  freeze everything while in RUN
//   abort     in   1  leave RUN for IDLE, keeping the datapath values
//   a, b      out  W  accumulators
//   n         out  W  captured bound
//   i         out  W  iteration count
//   busy      out  1  in RUN
//   done      out  1  in DONE
//   wrap      out  1  sticky: some accumulator update carried out of W bits
//   inv_ok    out  1  (a+b) == (STEP_LO+STEP_HI)*i, modulo 2^W
module step_accum_pair #(
  parameter int unsigned W       = 11,
  parameter int unsigned STEP_LO = 1,
  parameter int unsigned STEP_HI = 2,
  parameter int unsigned N_RST   = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] bound_in,
  input  logic         sel,
  input  logic         hold,
  input  logic         abort,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] n,
  output logic [W-1:0] i,
  output logic         busy,
  output logic         done,
  output logic         wrap,
  output logic         inv_ok
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [W-1:0] INC_LO   = W'(STEP_LO);
  localparam logic [W-1:0] INC_HI   = W'(STEP_HI);
  localparam logic [W-1:0] STEP_SUM = W'(STEP_LO + STEP_HI);
  localparam logic [W-1:0] N_INIT   = W'(N_RST);

  logic [1:0]   state_reg;
  logic [1:0]   state_next;
  logic [W-1:0] a_next;
  logic [W-1:0] b_next;
  logic [W-1:0] n_next;
  logic [W-1:0] i_next;
  logic         wrap_next;

  // Index 0 is accumulator a, index 1 is accumulator b. The sums are one
  // bit wider so the carry out of W bits feeds the sticky wrap flag.
  logic [W-1:0] acc_cur [2];
  logic [W-1:0] acc_inc [2];
  logic [W:0]   acc_sum [2];

  assign acc_cur[0] = a;
  assign acc_cur[1] = b;
  assign acc_inc[0] = sel ? INC_LO : INC_HI;
  assign acc_inc[1] = sel ? INC_HI : INC_LO;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_acc
      assign acc_sum[gi] = {1'b0, acc_cur[gi]} + {1'b0, acc_inc[gi]};
    end
  endgenerate

  logic [W-1:0] i_inc;
  assign i_inc = i + W'(1);

  always_comb begin
    state_next = state_reg;
    a_next     = a;
    b_next     = b;
    n_next     = n;
    i_next     = i;
    wrap_next  = wrap;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // A zero bound has no work to do, so it goes straight to DONE.
          state_next = (bound_in != '0) ? ST_RUN : ST_DONE;
          n_next     = bound_in;
          a_next     = '0;
          b_next     = '0;
          i_next     = '0;
          wrap_next  = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (hold) begin
          state_next = ST_RUN;
        end else if (i < n) begin
          a_next    = acc_sum[0][W-1:0];
          b_next    = acc_sum[1][W-1:0];
          i_next    = i_inc;
          wrap_next = wrap | acc_sum[0][W] | acc_sum[1][W];
          // Final step and the move to DONE share one edge.
          if (i_inc == n) begin
            state_next = ST_DONE;
          end
        end else begin
          // Not reachable in normal operation; recover without stepping.
          state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a         <= '0;
      b         <= '0;
      n         <= N_INIT;
      i         <= '0;
      wrap      <= 1'b0;
    end else begin
      state_reg <= state_next;
      a         <= a_next;
      b         <= b_next;
      n         <= n_next;
      i         <= i_next;
      wrap      <= wrap_next;
    end
  end

  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_DONE);

  // Every step adds STEP_LO+STEP_HI to a+b regardless of sel, so the sum
  // of the accumulators always tracks that constant times i.
  logic [W-1:0] ab_sum;
  logic [W-1:0] inv_rhs;
  assign ab_sum  = a + b;
  assign inv_rhs = STEP_SUM * i;
  assign inv_ok  = (ab_sum == inv_rhs);

endmodule

// File: tb/tb_step_accum_pair.sv
// Testbench for step_accum_pair: a directed vector table, hand-written
// multi-cycle sequences (full run, mid-run reset/abort, W=8 wrap) and a
// randomized phase checked against an arithmetic reference model.
module tb_step_accum_pair;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance (W=11)
  logic        rst, start, sel, hold, abort;
  logic [10:0] bound_in;
  logic [10:0] a, b, n, i;
  logic        busy, done, wrap, inv_ok;

  step_accum_pair dut (
    .clk(clk), .rst(rst), .start(start), .bound_in(bound_in), .sel(sel),
    .hold(hold), .abort(abort), .a(a), .b(b), .n(n), .i(i),
    .busy(busy), .done(done), .wrap(wrap), .inv_ok(inv_ok)
  );

  // W=8 instance for the wrap behaviour
  logic       rst8, start8, sel8, hold8, abort8;
  logic [7:0] bound8;
  logic [7:0] a8, b8, n8, i8;
  logic       busy8, done8, wrap8, inv_ok8;

  step_accum_pair #(.W(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .bound_in(bound8), .sel(sel8),
    .hold(hold8), .abort(abort8), .a(a8), .b(b8), .n(n8), .i(i8),
    .busy(busy8), .done(done8), .wrap(wrap8), .inv_ok(inv_ok8)
  );

  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic quiet();
    rst = 1'b0; start = 1'b0; sel = 1'b0; hold = 1'b0; abort = 1'b0;
    bound_in = '0;
  endtask

  typedef struct {
    bit rst; bit start; bit sel; bit hold; bit abort;
    int bound;
    int ea; int eb; int ei; int en;
    bit ebusy; bit edone;
  } vec_t;

  vec_t tbl[16];

  // Reference model state (W=11)
  localparam int M = 2048;
  int  m_mode;  // 0 idle, 1 run, 2 done
  int  ma, mb, mi, mn;
  bit  mw;

  initial begin
    quiet();
    rst = 1'b1;
    rst8 = 1'b1; start8 = 1'b0; sel8 = 1'b0; hold8 = 1'b0; abort8 = 1'b0;
    bound8 = '0;

    // Directed table: inputs applied for one edge, outputs checked after it.
    tbl[0]  = '{1,0,0,0,0, 0,  0,0,0,200, 0,0};  // reset
    tbl[1]  = '{0,1,0,0,0, 6,  0,0,0,6,   1,0};  // launch n=6
    tbl[2]  = '{0,0,1,0,0, 0,  1,2,1,6,   1,0};
    tbl[3]  = '{0,0,0,0,0, 0,  3,3,2,6,   1,0};
    tbl[4]  = '{0,0,1,1,0, 0,  3,3,2,6,   1,0};  // hold
    tbl[5]  = '{0,0,0,1,0, 0,  3,3,2,6,   1,0};  // hold
    tbl[6]  = '{0,0,1,0,0, 0,  4,5,3,6,   1,0};
    tbl[7]  = '{0,0,0,0,0, 0,  6,6,4,6,   1,0};
    tbl[8]  = '{0,0,1,0,0, 0,  7,8,5,6,   1,0};
    tbl[9]  = '{0,0,0,0,0, 0,  9,9,6,6,   0,1};  // done 9 edges after start
    tbl[10] = '{0,0,0,0,0, 0,  9,9,6,6,   0,1};  // DONE holds
    tbl[11] = '{0,1,0,0,0, 0,  0,0,0,0,   0,1};  // zero bound -> DONE
    tbl[12] = '{0,1,1,0,0, 3,  0,0,0,3,   1,0};  // relaunch from DONE
    tbl[13] = '{0,1,1,0,0, 7,  1,2,1,3,   1,0};  // start ignored in RUN
    tbl[14] = '{0,0,0,0,1, 0,  1,2,1,3,   0,0};  // abort
    tbl[15] = '{0,0,0,0,0, 0,  1,2,1,3,   0,0};  // IDLE holds

    for (int k = 0; k < 16; k++) begin
      rst = tbl[k].rst; start = tbl[k].start; sel = tbl[k].sel;
      hold = tbl[k].hold; abort = tbl[k].abort; bound_in = 11'(tbl[k].bound);
      tick();
      check($sformatf("tbl%0d.a", k), int'(a), tbl[k].ea);
      check($sformatf("tbl%0d.b", k), int'(b), tbl[k].eb);
      check($sformatf("tbl%0d.i", k), int'(i), tbl[k].ei);
      check($sformatf("tbl%0d.n", k), int'(n), tbl[k].en);
      check($sformatf("tbl%0d.busy", k), int'(busy), int'(tbl[k].ebusy));
      check($sformatf("tbl%0d.done", k), int'(done), int'(tbl[k].edone));
      check($sformatf("tbl%0d.wrap", k), int'(wrap), 0);
      check($sformatf("tbl%0d.inv_ok", k), int'(inv_ok), 1);
    end

    // Full default run: bound 200, sel=1
    begin
      int cnt;
      quiet(); rst = 1'b1; tick();
      quiet(); start = 1'b1; bound_in = 11'd200; sel = 1'b1; tick();
      start = 1'b0;
      cnt = 0;
      while (busy && cnt < 1000) begin
        tick();
        cnt++;
      end
      check("run200.busy_cycles", cnt, 200);
      check("run200.done", int'(done), 1);
      check("run200.a", int'(a), 200);
      check("run200.b", int'(b), 400);
      check("run200.i", int'(i), 200);
      check("run200.sum", int'(a) + int'(b), 600);
      check("run200.wrap", int'(wrap), 0);
      check("run200.inv_ok", int'(inv_ok), 1);
    end

    // Reset mid-run at i=50
    quiet(); start = 1'b1; bound_in = 11'd200; tick();
    start = 1'b0;
    repeat (50) tick();
    check("midrst.i_before", int'(i), 50);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst.busy", int'(busy), 0);
    check("midrst.done", int'(done), 0);
    check("midrst.a", int'(a), 0);
    check("midrst.b", int'(b), 0);
    check("midrst.i", int'(i), 0);
    check("midrst.n", int'(n), 200);

    // Abort mid-run at i=50, sel=0
    quiet(); start = 1'b1; bound_in = 11'd200; tick();
    start = 1'b0;
    repeat (50) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort.busy", int'(busy), 0);
    check("abort.done", int'(done), 0);
    check("abort.a", int'(a), 100);
    check("abort.b", int'(b), 50);
    check("abort.i", int'(i), 50);
    check("abort.n", int'(n), 200);
    tick();
    check("abort.idle_hold_a", int'(a), 100);

    // W=8: a steps by 2 for 200 steps and wraps
    begin
      int cnt;
      rst8 = 1'b1; tick(); rst8 = 1'b0;
      check("w8.rst_n", int'(n8), 200);
      start8 = 1'b1; bound8 = 8'd200; sel8 = 1'b0; tick(); start8 = 1'b0;
      cnt = 0;
      while (!done8 && cnt < 1000) begin
        tick();
        cnt++;
      end
      check("w8.cycles", cnt, 200);
      check("w8.a", int'(a8), 144);
      check("w8.b", int'(b8), 200);
      check("w8.wrap", int'(wrap8), 1);
      check("w8.inv_ok", int'(inv_ok8), 1);
      tick();
      check("w8.wrap_sticky", int'(wrap8), 1);
      start8 = 1'b1; bound8 = 8'd5; tick(); start8 = 1'b0;
      check("w8.wrap_clr", int'(wrap8), 0);
      check("w8.a_clr", int'(a8), 0);
    end

    // Randomized phase against the reference model
    quiet(); rst = 1'b1; tick();
    m_mode = 0; ma = 0; mb = 0; mi = 0; mn = 200; mw = 0;
    for (int c = 0; c < 400; c++) begin
      bit r_rst, r_start, r_sel, r_hold, r_abort;
      int r_bound, inca, incb;
      bit exp_inv, bad;
      r_rst   = ($urandom_range(0, 99) == 0);
      r_start = ($urandom_range(0, 2) == 0);
      r_bound = $urandom_range(0, 12);
      r_sel   = 1'($urandom_range(0, 1));
      r_hold  = ($urandom_range(0, 3) == 0);
      r_abort = ($urandom_range(0, 29) == 0);
      rst = r_rst; start = r_start; bound_in = 11'(r_bound); sel = r_sel;
      hold = r_hold; abort = r_abort;
      tick();

      if (r_rst) begin
        m_mode = 0; ma = 0; mb = 0; mi = 0; mn = 200; mw = 0;
      end else if (m_mode != 1) begin
        if (r_start) begin
          mn = r_bound; ma = 0; mb = 0; mi = 0; mw = 0;
          m_mode = (r_bound != 0) ? 1 : 2;
        end
      end else if (r_abort) begin
        m_mode = 0;
      end else if (!r_hold) begin
        if (mi < mn) begin
          inca = r_sel ? 1 : 2;
          incb = r_sel ? 2 : 1;
          if (ma + inca >= M || mb + incb >= M) mw = 1;
          ma = (ma + inca) % M;
          mb = (mb + incb) % M;
          mi = mi + 1;
          if (mi == mn) m_mode = 2;
        end else begin
          m_mode = 2;
        end
      end

      exp_inv = (((ma + mb) % M) == ((3 * mi) % M));
      bad = (int'(a) != ma) || (int'(b) != mb) || (int'(i) != mi) ||
            (int'(n) != mn) || (busy != (m_mode == 1)) ||
            (done != (m_mode == 2)) || (wrap != mw) || (inv_ok != exp_inv);
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL rand%0d: got a=%0d b=%0d i=%0d n=%0d busy=%0d done=%0d wrap=%0d inv=%0d expected a=%0d b=%0d i=%0d n=%0d busy=%0d done=%0d wrap=%0d inv=%0d",
                 c, a, b, i, n, busy, done, wrap, inv_ok,
                 ma, mb, mi, mn, (m_mode == 1), (m_mode == 2), mw, exp_inv);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
